// File: rtl/sparc_rf_pkg.sv
// Shared definitions for the SPARC V8 windowed register file: sizing
// constants, index typedefs and the architectural-to-physical mapping.
package sparc_rf_pkg;

    localparam int NWINDOWS    = 4;
    localparam int NGLOBALS    = 8;
    localparam int WINDOW_REGS = 16;
    localparam int NPHYS       = NGLOBALS + WINDOW_REGS * NWINDOWS;

    typedef logic [$clog2(NWINDOWS)-1:0] cwp_t;
    typedef logic [$clog2(NPHYS)-1:0]    phys_idx_t;

    // Maps an architectural register to its physical slot. The result is
    // wide enough for the largest legal file (32 windows, 520 registers).
    // Globals map straight through. Windowed registers sit 16 apart per
    // window, so the outs of window w land on the ins of window w-1, and
    // the ins of the top window wrap back onto physical 8-15. nwin is a
    // power of two, so the modulo is a mask.
    function automatic logic [9:0] arch_to_phys(
        input logic [4:0]  rd,
        input logic [4:0]  cwp,
        input int unsigned nwin = NWINDOWS
    );
        logic [9:0] sum;
        logic [9:0] mask;
        if (rd < 5'(NGLOBALS)) begin
            return {5'd0, rd};
        end
        mask = 10'(WINDOW_REGS * nwin - 1);
        sum  = {1'b0, cwp, 4'd0} + {5'd0, rd - 5'(NGLOBALS)};
        return 10'(NGLOBALS) + (sum & mask);
    endfunction

endpackage

// File: rtl/regfile_write_decoder_cwp_unit.sv
// Current Window Pointer register with SAVE/RESTORE stepping, PSR loads
// and WIM-based overflow/underflow trap generation.
module cwp_unit
    import sparc_rf_pkg::*;
#(
    parameter  int NWINDOWS = sparc_rf_pkg::NWINDOWS,
    localparam int CW       = $clog2(NWINDOWS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cwp_save,
    input  logic                cwp_restore,
    input  logic                cwp_load,
    input  logic [CW-1:0]       cwp_in,
    input  logic [NWINDOWS-1:0] wim,
    output logic [CW-1:0]       cwp,
    output logic                ovf_trap,
    output logic                unf_trap
);

    logic [CW-1:0] cwp_q, cwp_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [CW-1:0] save_target;
    logic [CW-1:0] restore_target;

    // Next-state CWP and trap pulses in priority order: load, conflicting
    // SAVE+RESTORE, SAVE, RESTORE. Steps wrap naturally at CW bits.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cwp_d          = cwp_q;
        ovf_d          = 1'b0;
        unf_d          = 1'b0;
        save_target    = cwp_q - 1'b1;
        restore_target = cwp_q + 1'b1;
        if (cwp_load) begin
            cwp_d = cwp_in;
        end else if (cwp_save && cwp_restore) begin
            cwp_d = cwp_q;
        end else if (cwp_save) begin
            if (wim[save_target]) begin
                ovf_d = 1'b1;
            end else begin
                cwp_d = save_target;
            end
        end else if (cwp_restore) begin
            if (wim[restore_target]) begin
                unf_d = 1'b1;
            end else begin
                cwp_d = restore_target;
            end
        end
    end

    // CWP and trap registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cwp_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cwp_q <= cwp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign cwp      = cwp_q;
    assign ovf_trap = ovf_q;
    assign unf_trap = unf_q;

endmodule

// File: rtl/regfile_write_decoder.sv
// Write-side decoder for the SPARC V8 windowed register file: turns one
// architectural write per cycle into a registered one-hot physical write,
// mapping windowed registers through the CWP held at the start of the cycle.
module regfile_write_decoder
    import sparc_rf_pkg::*;
#(
    parameter  int NWINDOWS = sparc_rf_pkg::NWINDOWS,
    localparam int NPHYS    = NGLOBALS + WINDOW_REGS * NWINDOWS,
    localparam int CW       = $clog2(NWINDOWS),
    localparam int PW       = $clog2(NPHYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_req,
    input  logic [4:0]          wr_rd,
    input  logic [31:0]         wr_data,
    input  logic                cwp_save,
    input  logic                cwp_restore,
    input  logic                cwp_load,
    input  logic [CW-1:0]       cwp_in,
    input  logic [NWINDOWS-1:0] wim,
    output logic [NPHYS-1:0]    pwr_en,
    output logic [PW-1:0]       pwr_idx,
    output logic [31:0]         pwr_data,
    output logic [CW-1:0]       cwp,
    output logic                ovf_trap,
    output logic                unf_trap
);

    logic [NPHYS-1:0] pwr_en_q, pwr_en_d;
    logic [PW-1:0]    pwr_idx_q, pwr_idx_d;
    logic [31:0]      pwr_data_q, pwr_data_d;
    logic [CW-1:0]    cwp_cur;
    logic [PW-1:0]    phys_idx;

    cwp_unit #(
        .NWINDOWS (NWINDOWS)
    ) u_cwp_unit (
        .clk         (clk),
        .reset       (reset),
        .cwp_save    (cwp_save),
        .cwp_restore (cwp_restore),
        .cwp_load    (cwp_load),
        .cwp_in      (cwp_in),
        .wim         (wim),
        .cwp         (cwp_cur),
        .ovf_trap    (ovf_trap),
        .unf_trap    (unf_trap)
    );

    // Map the request through the current (pre-update) CWP.
    assign phys_idx = PW'(arch_to_phys(wr_rd, 5'(cwp_cur), NWINDOWS));

    // Build the next physical write: %g0 gets no enable but still updates
    // index and data; idle cycles clear the enable and hold index/data.
    always_comb begin
        pwr_en_d   = '0;
        pwr_idx_d  = pwr_idx_q;
        pwr_data_d = pwr_data_q;
        if (wr_req) begin
            pwr_idx_d  = phys_idx;
            pwr_data_d = wr_data;
            if (wr_rd != 5'd0) begin
                pwr_en_d[phys_idx] = 1'b1;
            end
        end
    end

    // Physical write port registers; reset drops any write in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwr_en_q   <= '0;
            pwr_idx_q  <= '0;
            pwr_data_q <= '0;
        end else begin
            pwr_en_q   <= pwr_en_d;
            pwr_idx_q  <= pwr_idx_d;
            pwr_data_q <= pwr_data_d;
        end
    end

    assign pwr_en   = pwr_en_q;
    assign pwr_idx  = pwr_idx_q;
    assign pwr_data = pwr_data_q;
    assign cwp      = cwp_cur;

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Directed bench for regfile_write_decoder at NWINDOWS = 4 (72 physical
// registers); expected values are hand-computed from the mapping rules.
module tb_regfile_write_decoder;

    localparam int NWIN = 4;
    localparam int NPH  = 72;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_req;
    logic [4:0]      wr_rd;
    logic [31:0]     wr_data;
    logic            cwp_save;
    logic            cwp_restore;
    logic            cwp_load;
    logic [1:0]      cwp_in;
    logic [NWIN-1:0] wim;
    logic [NPH-1:0]  pwr_en;
    logic [6:0]      pwr_idx;
    logic [31:0]     pwr_data;
    logic [1:0]      cwp;
    logic            ovf_trap;
    logic            unf_trap;

    int total = 0;
    int bad   = 0;

    regfile_write_decoder #(
        .NWINDOWS (NWIN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_req      (wr_req),
        .wr_rd       (wr_rd),
        .wr_data     (wr_data),
        .cwp_save    (cwp_save),
        .cwp_restore (cwp_restore),
        .cwp_load    (cwp_load),
        .cwp_in      (cwp_in),
        .wim         (wim),
        .pwr_en      (pwr_en),
        .pwr_idx     (pwr_idx),
        .pwr_data    (pwr_data),
        .cwp         (cwp),
        .ovf_trap    (ovf_trap),
        .unf_trap    (unf_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock, then settle past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] onehot(input int i);
        logic [127:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic idle_inputs();
        wr_req      = 1'b0;
        wr_rd       = 5'd0;
        wr_data     = 32'd0;
        cwp_save    = 1'b0;
        cwp_restore = 1'b0;
        cwp_load    = 1'b0;
        cwp_in      = 2'd0;
    endtask

    task automatic load_cwp(input logic [1:0] v);
        idle_inputs();
        cwp_load = 1'b1;
        cwp_in   = v;
        step();
        cwp_load = 1'b0;
    endtask

    task automatic write_and_check(input string tag, input logic [4:0] rd,
                                   input logic [31:0] d, input int exp_idx);
        idle_inputs();
        wr_req  = 1'b1;
        wr_rd   = rd;
        wr_data = d;
        step();
        wr_req = 1'b0;
        check({tag, "_en"}, 128'(pwr_en), onehot(exp_idx));
        check({tag, "_idx"}, 128'(pwr_idx), 128'(exp_idx));
        check({tag, "_data"}, 128'(pwr_data), 128'(d));
    endtask

    initial begin
        idle_inputs();
        wim   = '0;
        reset = 1'b1;
        step();
        step();
        check("rst_en", 128'(pwr_en), 128'd0);
        check("rst_idx", 128'(pwr_idx), 128'd0);
        check("rst_data", 128'(pwr_data), 128'd0);
        check("rst_cwp", 128'(cwp), 128'd0);
        check("rst_ovf", 128'(ovf_trap), 128'd0);
        check("rst_unf", 128'(unf_trap), 128'd0);
        reset = 1'b0;

        // Global write, then idle cycle clears enable and holds index/data.
        write_and_check("g5", 5'd5, 32'hDEADBEEF, 5);
        step();
        check("g5_idle_en", 128'(pwr_en), 128'd0);
        check("g5_idle_idx", 128'(pwr_idx), 128'd5);
        check("g5_idle_data", 128'(pwr_data), 128'hDEADBEEF);

        // %g0: no enable, index/data still update.
        idle_inputs();
        wr_req  = 1'b1;
        wr_rd   = 5'd0;
        wr_data = 32'h1234_5678;
        step();
        check("g0_en", 128'(pwr_en), 128'd0);
        check("g0_idx", 128'(pwr_idx), 128'd0);
        check("g0_data", 128'(pwr_data), 128'h1234_5678);

        // Window mapping at cwp=0 and wrap at cwp=3.
        write_and_check("w0_r8", 5'd8, 32'hA0A0_0008, 8);
        write_and_check("w0_r31", 5'd31, 32'hA0A0_001F, 31);
        load_cwp(2'd3);
        check("load3_cwp", 128'(cwp), 128'd3);
        write_and_check("w3_r24", 5'd24, 32'hB3B3_0018, 8);
        write_and_check("w3_r16", 5'd16, 32'hB3B3_0010, 64);
        write_and_check("w3_r8", 5'd8, 32'hB3B3_0008, 56);

        // SAVE wraps 0 -> 3 without trap; outs of window 0 alias ins of 3.
        load_cwp(2'd0);
        idle_inputs();
        cwp_save = 1'b1;
        step();
        cwp_save = 1'b0;
        check("save_wrap_cwp", 128'(cwp), 128'd3);
        check("save_wrap_ovf", 128'(ovf_trap), 128'd0);
        write_and_check("alias_r24", 5'd24, 32'hC0DE_0018, 8);

        // RESTORE wraps 3 -> 0 without trap.
        idle_inputs();
        cwp_restore = 1'b1;
        step();
        cwp_restore = 1'b0;
        check("rest_wrap_cwp", 128'(cwp), 128'd0);
        check("rest_wrap_unf", 128'(unf_trap), 128'd0);

        // Overflow: SAVE from 1 into invalid window 0.
        load_cwp(2'd1);
        wim      = 4'b0001;
        cwp_save = 1'b1;
        step();
        cwp_save = 1'b0;
        check("ovf_pulse", 128'(ovf_trap), 128'd1);
        check("ovf_cwp", 128'(cwp), 128'd1);
        check("ovf_unf", 128'(unf_trap), 128'd0);
        step();
        check("ovf_clear", 128'(ovf_trap), 128'd0);
        check("ovf_cwp_hold", 128'(cwp), 128'd1);

        // Underflow: RESTORE from 3 into invalid window 0.
        load_cwp(2'd3);
        cwp_restore = 1'b1;
        step();
        cwp_restore = 1'b0;
        check("unf_pulse", 128'(unf_trap), 128'd1);
        check("unf_cwp", 128'(cwp), 128'd3);
        check("unf_ovf", 128'(ovf_trap), 128'd0);
        step();
        check("unf_clear", 128'(unf_trap), 128'd0);
        wim = '0;

        // SAVE and RESTORE together: no change.
        cwp_save    = 1'b1;
        cwp_restore = 1'b1;
        step();
        idle_inputs();
        check("both_cwp", 128'(cwp), 128'd3);
        check("both_ovf", 128'(ovf_trap), 128'd0);
        check("both_unf", 128'(unf_trap), 128'd0);

        // Load beats SAVE even when the SAVE target (2) is marked invalid.
        wim      = 4'b0100;
        cwp_load = 1'b1;
        cwp_in   = 2'd2;
        cwp_save = 1'b1;
        step();
        idle_inputs();
        wim = '0;
        check("load_save_cwp", 128'(cwp), 128'd2);
        check("load_save_ovf", 128'(ovf_trap), 128'd0);

        // Write alongside a SAVE from cwp=1 maps with the old CWP.
        load_cwp(2'd1);
        wr_req   = 1'b1;
        wr_rd    = 5'd8;
        wr_data  = 32'h5AFE_0008;
        cwp_save = 1'b1;
        step();
        idle_inputs();
        check("oldcwp_idx", 128'(pwr_idx), 128'd24);
        check("oldcwp_en", 128'(pwr_en), onehot(24));
        check("oldcwp_cwp", 128'(cwp), 128'd0);
        write_and_check("newcwp_r8", 5'd8, 32'h5AFE_1008, 8);

        // Back-to-back writes, one per cycle.
        wr_req  = 1'b1;
        wr_rd   = 5'd9;
        wr_data = 32'h0000_0009;
        step();
        check("b2b0_idx", 128'(pwr_idx), 128'd9);
        wr_rd   = 5'd3;
        wr_data = 32'h0000_0003;
        step();
        check("b2b1_idx", 128'(pwr_idx), 128'd3);
        check("b2b1_en", 128'(pwr_en), onehot(3));

        // Reset with a write in flight drops it.
        load_cwp(2'd2);
        reset   = 1'b1;
        wr_req  = 1'b1;
        wr_rd   = 5'd5;
        wr_data = 32'hFFFF_FFFF;
        step();
        check("rst_wr_en", 128'(pwr_en), 128'd0);
        check("rst_wr_idx", 128'(pwr_idx), 128'd0);
        check("rst_wr_data", 128'(pwr_data), 128'd0);
        check("rst_wr_cwp", 128'(cwp), 128'd0);
        reset = 1'b0;
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
